// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside
//   the ID-stage Control decoder and:
//     - bubbles the pipe on load-use hazards
//     - freezes the pipe while a multi-cycle MUL occupies EX
//     - flushes IF/ID on taken branches
//   It also keeps a saturating count of the cycles in which the PC was held.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous reset, active low
//   start_i        : CPU start, only looked at while idle
//   ID_opcode_i    : opcode of the instruction in ID
//   ID_funct3_i    : funct3 of the instruction in ID
//   ID_funct7_i    : funct7 of the instruction in ID
//   ID_rs1_i       : rs1 of the instruction in ID
//   ID_rs2_i       : rs2 of the instruction in ID
//   EX_MemRead_i   : ID/EX MemRead (a load is in EX)
//   EX_rd_i        : ID/EX destination register
//   branch_taken_i : ID comparator result (beq condition true)
//   PCWrite_o      : PC update enable
//   IFID_Write_o   : IF/ID register write enable
//   IFID_Flush_o   : zero the IF/ID contents at the next edge
//   NoOp_o         : force all Control outputs to 0 (bubble into ID/EX)
//   pipe_hold_o    : hold ID/EX, EX/MEM and MEM/WB
//   stall_cycles_o : saturating count of cycles with PCWrite_o=0 after start

module hazard_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 4,
    parameter int STALL_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [6:0]         ID_opcode_i,
    input  logic [2:0]         ID_funct3_i,
    input  logic [6:0]         ID_funct7_i,
    input  logic [4:0]         ID_rs1_i,
    input  logic [4:0]         ID_rs2_i,
    input  logic               EX_MemRead_i,
    input  logic [4:0]         EX_rd_i,
    input  logic               branch_taken_i,
    output logic               PCWrite_o,
    output logic               IFID_Write_o,
    output logic               IFID_Flush_o,
    output logic               NoOp_o,
    output logic               pipe_hold_o,
    output logic [STALL_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MUL_WAIT = 2'd2
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // A single-cycle MUL never needs the freeze.
    localparam bit MUL_FREEZE = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] MUL_WAIT_CYCLES = CNT_W'(MUL_LATENCY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic uses_rs2;
    logic is_mul;
    logic is_beq;
    logic load_use;

    // Instruction decode for the hazard checks. rs2 only matters for formats
    // that actually read it; the rs2 field of an I-type is immediate bits.
    always_comb begin
        uses_rs2 = (ID_opcode_i == OP_RTYPE) || (ID_opcode_i == OP_STORE) ||
                   (ID_opcode_i == OP_BRANCH);
        is_mul   = (ID_opcode_i == OP_RTYPE) && (ID_funct7_i == 7'b0000001) &&
                   (ID_funct3_i == 3'b000);
        is_beq   = (ID_opcode_i == OP_BRANCH);
        load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                   ((EX_rd_i == ID_rs1_i) || (uses_rs2 && (EX_rd_i == ID_rs2_i)));
    end

    always_comb begin
        state_d      = state_q;
        mul_cnt_d    = mul_cnt_q;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
        IFID_Flush_o = 1'b0;
        NoOp_o       = 1'b0;
        pipe_hold_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                NoOp_o = 1'b1;
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_use) begin
                    // A branch hidden behind a load-use bubble is re-evaluated
                    // next cycle, so no flush here.
                    NoOp_o = 1'b1;
                end else begin
                    PCWrite_o    = 1'b1;
                    IFID_Write_o = 1'b1;
                    if (is_mul && MUL_FREEZE) begin
                        // The MUL issues normally this cycle; the freeze covers
                        // the remaining cycles it spends in EX.
                        state_d   = MUL_WAIT;
                        mul_cnt_d = MUL_WAIT_CYCLES;
                    end else if (is_beq && branch_taken_i) begin
                        IFID_Flush_o = 1'b1;
                    end
                end
            end
            MUL_WAIT: begin
                pipe_hold_o = 1'b1;
                mul_cnt_d   = mul_cnt_q - CNT_W'(1);
                if (mul_cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counts held-PC cycles only once the core is running; sticks at all-ones.
    always_comb begin
        stall_d = stall_q;
        if ((state_q != IDLE) && !PCWrite_o && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
//   Drives two hazard_sequencer instances with identical stimulus: one with
//   the default 16-bit stall counter and one with a 4-bit counter so that
//   saturation is reached quickly. Outputs are compared against a cycle-level
//   reference model written from the sequencing rules (started flag, number of
//   freeze cycles left, unbounded stall count).

module tb_hazard_sequencer;

    localparam int LAT      = 3;
    localparam int BIG_W    = 16;
    localparam int SMALL_W  = 4;
    localparam int BIG_MAX  = (1 << BIG_W) - 1;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic       clk;
    logic       rstN;
    logic       start;
    logic [6:0] idOpcode;
    logic [2:0] idFunct3;
    logic [6:0] idFunct7;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       exMemRead;
    logic [4:0] exRd;
    logic       branchTaken;

    logic               pcWrite, ifidWrite, ifidFlush, noOp, pipeHold;
    logic [BIG_W-1:0]   stallBig;
    logic               pcWriteS, ifidWriteS, ifidFlushS, noOpS, pipeHoldS;
    logic [SMALL_W-1:0] stallSmall;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit modelStarted;
    int modelHoldLeft;
    int modelStalls;

    hazard_sequencer #(.MUL_LATENCY(LAT), .CNT_W(4), .STALL_W(BIG_W)) dutBig (
        .clk_i(clk), .rst_i(rstN), .start_i(start),
        .ID_opcode_i(idOpcode), .ID_funct3_i(idFunct3), .ID_funct7_i(idFunct7),
        .ID_rs1_i(idRs1), .ID_rs2_i(idRs2),
        .EX_MemRead_i(exMemRead), .EX_rd_i(exRd), .branch_taken_i(branchTaken),
        .PCWrite_o(pcWrite), .IFID_Write_o(ifidWrite), .IFID_Flush_o(ifidFlush),
        .NoOp_o(noOp), .pipe_hold_o(pipeHold), .stall_cycles_o(stallBig)
    );

    hazard_sequencer #(.MUL_LATENCY(LAT), .CNT_W(4), .STALL_W(SMALL_W)) dutSmall (
        .clk_i(clk), .rst_i(rstN), .start_i(start),
        .ID_opcode_i(idOpcode), .ID_funct3_i(idFunct3), .ID_funct7_i(idFunct7),
        .ID_rs1_i(idRs1), .ID_rs2_i(idRs2),
        .EX_MemRead_i(exMemRead), .EX_rd_i(exRd), .branch_taken_i(branchTaken),
        .PCWrite_o(pcWriteS), .IFID_Write_o(ifidWriteS), .IFID_Flush_o(ifidFlushS),
        .NoOp_o(noOpS), .pipe_hold_o(pipeHoldS), .stall_cycles_o(stallSmall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rs1,
                            input logic [4:0] rs2);
        idOpcode = op;
        idFunct3 = f3;
        idFunct7 = f7;
        idRs1    = rs1;
        idRs2    = rs2;
    endtask

    task automatic setEx(input logic memRead, input logic [4:0] rd, input logic taken);
        exMemRead   = memRead;
        exRd        = rd;
        branchTaken = taken;
    endtask

    task automatic modelReset();
        modelStarted  = 1'b0;
        modelHoldLeft = 0;
        modelStalls   = 0;
    endtask

    function automatic int satTo(input int value, input int maxVal);
        return (value > maxVal) ? maxVal : value;
    endfunction

    // Checks one cycle's outputs at the falling edge against the model, then
    // advances the model across the following rising edge.
    task automatic applyStimulus(input string tag);
        logic expPc, expIfid, expFlush, expNoOp, expHold;
        bit   loadUse, readsRs2, isMul, isBeq;
        bit   nextStarted;
        int   nextHold, nextStalls;

        @(negedge clk);
        readsRs2 = (idOpcode inside {7'b0110011, 7'b0100011, 7'b1100011});
        isMul    = (idOpcode == 7'b0110011) && (idFunct7 == 7'b0000001) && (idFunct3 == 3'b000);
        isBeq    = (idOpcode == 7'b1100011);
        loadUse  = exMemRead && (exRd != 0) &&
                   ((exRd == idRs1) || (readsRs2 && (exRd == idRs2)));

        expPc = 0; expIfid = 0; expFlush = 0; expNoOp = 0; expHold = 0;
        nextStarted = modelStarted;
        nextHold    = modelHoldLeft;
        nextStalls  = modelStalls;

        if (!modelStarted) begin
            expNoOp = 1;
            nextStarted = start;
        end else if (modelHoldLeft > 0) begin
            expHold  = 1;
            nextHold = modelHoldLeft - 1;
            nextStalls++;
        end else if (loadUse) begin
            expNoOp = 1;
            nextStalls++;
        end else begin
            expPc   = 1;
            expIfid = 1;
            if (isMul) nextHold = LAT - 1;
            else if (isBeq && branchTaken) expFlush = 1;
        end

        checkOutput({tag, ".PCWrite"},    32'(pcWrite),    32'(expPc));
        checkOutput({tag, ".IFID_Write"}, 32'(ifidWrite),  32'(expIfid));
        checkOutput({tag, ".IFID_Flush"}, 32'(ifidFlush),  32'(expFlush));
        checkOutput({tag, ".NoOp"},       32'(noOp),       32'(expNoOp));
        checkOutput({tag, ".pipe_hold"},  32'(pipeHold),   32'(expHold));
        checkOutput({tag, ".stall16"},    32'(stallBig),   32'(satTo(modelStalls, BIG_MAX)));
        checkOutput({tag, ".stall4"},     32'(stallSmall), 32'(satTo(modelStalls, SMALL_MAX)));
        checkOutput({tag, ".smallPC"},    32'({pcWriteS, ifidWriteS, ifidFlushS, noOpS, pipeHoldS}),
                    32'({expPc, expIfid, expFlush, expNoOp, expHold}));

        @(posedge clk);
        modelStarted  = nextStarted;
        modelHoldLeft = nextHold;
        modelStalls   = nextStalls;
        #1;
    endtask

    task automatic randomInputs();
        logic [6:0] ops [5];
        ops[0] = 7'b0110011; ops[1] = 7'b0100011; ops[2] = 7'b1100011;
        ops[3] = 7'b0010011; ops[4] = 7'b0000011;
        setInstr(ops[$urandom_range(0, 4)], ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom),
                 ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'($urandom),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        setEx(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
        start = 1'($urandom);
    endtask

    initial begin
        rstN  = 1'b0;
        start = 1'b0;
        setInstr(7'b0010011, 3'b000, 7'b0, 5'd0, 5'd0);
        setEx(1'b0, 5'd0, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.NoOp", 32'(noOp), 32'd1);
        checkOutput("reset.stall", 32'(stallBig), 32'd0);
        rstN = 1'b1;

        // Idle with start low, then start
        for (int i = 0; i < 5; i++) applyStimulus("idle");
        start = 1'b1;
        applyStimulus("start");
        start = 1'b0;
        applyStimulus("running");
        checkOutput("run.PCWrite", 32'(pcWrite), 32'd1);

        // lw x5 in EX, add x6,x5,x7 in ID
        setEx(1'b1, 5'd5, 1'b0);
        setInstr(7'b0110011, 3'b000, 7'b0, 5'd5, 5'd7);
        applyStimulus("loaduse");
        setEx(1'b0, 5'd5, 1'b0);
        applyStimulus("loaduse.after");
        checkOutput("loaduse.count", 32'(stallBig), 32'd1);

        // x0 destination, sw rs2 hazard, addi with rs2 field matching
        setEx(1'b1, 5'd0, 1'b0);
        setInstr(7'b0110011, 3'b000, 7'b0, 5'd0, 5'd0);
        applyStimulus("rdzero");
        setEx(1'b1, 5'd9, 1'b0);
        setInstr(7'b0100011, 3'b010, 7'b0, 5'd1, 5'd9);
        applyStimulus("sw.rs2");
        setInstr(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd9);
        applyStimulus("addi.rs2field");

        // MUL freeze and back-to-back MUL
        setEx(1'b0, 5'd0, 1'b0);
        setInstr(7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2);
        for (int i = 0; i < 7; i++) applyStimulus("mul");
        setInstr(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd2);
        applyStimulus("mul.done");

        // Taken beq without and with a load-use hazard
        setEx(1'b0, 5'd3, 1'b1);
        setInstr(7'b1100011, 3'b000, 7'b0, 5'd3, 5'd4);
        applyStimulus("beq");
        setEx(1'b1, 5'd3, 1'b1);
        applyStimulus("beq.blocked");
        setEx(1'b0, 5'd3, 1'b1);
        applyStimulus("beq.deferred");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomInputs();
            applyStimulus("rand");
        end

        // Reset in the middle of a MUL freeze
        setEx(1'b0, 5'd0, 1'b0);
        setInstr(7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2);
        while (!modelStarted || modelHoldLeft != 0) applyStimulus("premul");
        applyStimulus("mul.issue");
        checkOutput("mulwait.hold", 32'(pipeHold), 32'd1);
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset.hold", 32'(pipeHold), 32'd0);
        checkOutput("midreset.NoOp", 32'(noOp), 32'd1);
        checkOutput("midreset.PCWrite", 32'(pcWrite), 32'd0);
        checkOutput("midreset.stall16", 32'(stallBig), 32'd0);
        checkOutput("midreset.stall4", 32'(stallSmall), 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        start = 1'b0;
        applyStimulus("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
